bcd_digit_counter: RTL and testbench
====================================

# bcd_digit_counter

Two-digit BCD up/down counter that directly feeds the seven-segment display controller. It divides the board clock into the 500 Hz display scan clock (`clk_500Hz`) and a count tick. It drives the ones/tens digits (`dec0`/`dec1`) under start/stop, clear and direction control. It sits between the board buttons/switches and the display controller.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, input clock frequency.
- `TICK_HZ`, 1, count rate. `TICK_DIV = CLK_HZ/TICK_HZ` (integer, ≥2).
- `DISP_HZ`, 500, display scan clock frequency. `DISP_DIV = CLK_HZ/(2*DISP_HZ)` (integer, ≥1).
- `WRAP`, 1, 1 = wrap at terminal count; 0 = stop at terminal count and assert `done`.

Ports:
- `clk` input 1: board clock, rising-edge.
- `rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `btn_run` input 1: asynchronous button; each rising edge toggles run/stop.
- `btn_clear` input 1: asynchronous button; a rising edge clears the digits to 00.
- `up_dn` input 1: asynchronous switch; 1 = count up, 0 = count down.
- `dec0` output 4: ones digit, BCD 0–9.
- `dec1` output 4: tens digit, BCD 0–9.
- `clk_500Hz` output 1: 50% duty scan clock for the display controller.
- `running` output 1: high in RUN.
- `done` output 1: high in DONE (only reachable when `WRAP=0`).

## Operation
- **Synchronizers.** `btn_run`, `btn_clear` and `up_dn` each pass through a 2-FF synchronizer.
- **Edge detectors.** The run and clear paths each have a third register for edge detection. `run_p = s2 & ~s3`, `clr_p` likewise. Both are one-cycle pulses.
- **FSM states.**
  - IDLE: stopped, digits hold.
  - RUN: counting.
  - DONE: terminal count reached with `WRAP=0`; digits hold.
- **FSM transitions, priority top-down:**
  - `clr_p` in any state: digits ← 00, tick counter ← 0, state ← IDLE.
  - IDLE & `run_p` → RUN.
  - RUN & `run_p` → IDLE.
  - RUN & tick → count step (below).
  - DONE ignores `run_p`; only `clr_p` or reset leaves DONE.
- **Tick counter.**
  - Counts 0..TICK_DIV-1 only in RUN; held at 0 in IDLE and DONE.
  - `tick` is asserted when the counter is TICK_DIV-1 in RUN; the counter then returns to 0.
  - Stop/resume discards the partial period.
- **Count step on tick (synchronized `up_dn`):**
  - Up: ones +1; ones 9→0 with tens +1.
  - Down: ones −1; ones 0→9 with tens −1.
  - At terminal (99 up / 00 down): `WRAP=1` goes 99→00 / 00→99 and stays in RUN. `WRAP=0` holds the value and enters DONE.
  - Digits never leave the range 0–9.
- **Display divider.**
  - Free-running 0..DISP_DIV-1 regardless of FSM state; `clr_p` does not affect it.
  - `clk_500Hz` toggles when the divider is DISP_DIV-1.
- **Outputs.** All outputs are registered; no combinational path from inputs to outputs.

## Timing
- **Reset values:** `dec0`=0, `dec1`=0, `clk_500Hz`=0, `running`=0, `done`=0. State = IDLE, all counters and synchronizer FFs = 0.
- **Reset mid-operation:** all of the above take effect immediately, without waiting for a clock edge.
- **Button latency:** an input rising before clk edge 1 acts at edge 3.
  - `running` changes at edge 3.
  - A clear takes effect at edge 3.
- **Direction latency:** an `up_dn` change is used from the first tick at least 2 edges after the change.
- **First increment after entering RUN:** occurs exactly TICK_DIV edges after the RUN-entry edge.
  - Subsequent increments follow every TICK_DIV edges.
- **Digit update:** digits update on the same edge that consumes the tick.
- **DONE entry:** `done`=1 and `running`=0 on the same edge.
- **Simultaneous `clr_p` and `run_p`:** clear wins; the result is IDLE at 00.
- **Simultaneous tick and `run_p` (stop):** the stop wins; no count on that edge.
- **Scan clock:** `clk_500Hz` period is 2*DISP_DIV clk cycles. The first rising edge is at edge DISP_DIV after reset release.

## Test plan
Bench parameters: `CLK_HZ`=1000, `TICK_HZ`=100 (TICK_DIV=10), `DISP_HZ`=100 (DISP_DIV=5).

- **Reset/scan:** assert `rst_n`=0 mid-run.
  - All outputs go to 0 immediately.
  - After release, `clk_500Hz` rises at edge 5 and has period 10 clk cycles.
- **Up count across tens:** press `btn_run` with `up_dn`=1.
  - `running`=1 at edge 3.
  - `dec1:dec0` = 0:1 ten edges later.
  - After 10 ticks the value is 1:0.
  - 09→10 carry is correct; `dec0` never shows 10–15.
- **Wrap vs. stop at terminal:**
  - `WRAP=1`: up from 99 → 00 and still running. Down from 00 → 99.
  - `WRAP=0`: up at 99 → holds 99, `done`=1, `running`=0. A subsequent `btn_run` is ignored; `btn_clear` → 00, `done`=0.
- **Pause/resume:** stop at 0:7 and wait 50 cycles, value holds 0:7. Resume: 0:8 appears 10 edges after the RUN-entry edge.
- **Simultaneous events:**
  - `btn_run` and `btn_clear` rise in the same cycle while running → IDLE at 00.
  - Flip `up_dn` at value 0:5 → the next tick gives 0:4.

Source files
------------

// File: rtl/bcd_digit_counter.sv
// Two-digit BCD up/down counter with run/stop, clear and direction control.
// It also divides the board clock down to the display controller's scan clock.
module bcd_digit_counter #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1,
    parameter int DISP_HZ = 500,
    parameter bit WRAP    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_run,
    input  logic       btn_clear,
    input  logic       up_dn,
    output logic [3:0] dec0,
    output logic [3:0] dec1,
    output logic       clk_500Hz,
    output logic       running,
    output logic       done
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int DISP_DIV = CLK_HZ / (2 * DISP_HZ);
    localparam int TICK_W   = $clog2(TICK_DIV);
    localparam int DISP_W   = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(DISP_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit 0 = run button, bit 1 = clear button, bit 2 = direction switch.
    logic [2:0] raw_in;
    logic [2:0] sync_s2;

    assign raw_in = {up_dn, btn_clear, btn_run};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= raw_in[gi];
                    s2_reg <= s1_reg;
                end
            end

            assign sync_s2[gi] = s2_reg;
        end
    endgenerate

    logic run_s3_reg;
    logic clr_s3_reg;
    logic run_p;
    logic clr_p;
    logic up_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_s3_reg <= 1'b0;
            clr_s3_reg <= 1'b0;
        end else begin
            run_s3_reg <= sync_s2[0];
            clr_s3_reg <= sync_s2[1];
        end
    end

    assign run_p   = sync_s2[0] & ~run_s3_reg;
    assign clr_p   = sync_s2[1] & ~clr_s3_reg;
    assign up_sync = sync_s2[2];

    state_t            state_reg;
    logic [TICK_W-1:0] tick_cnt_reg;
    logic [3:0]        dec0_reg;
    logic [3:0]        dec1_reg;
    logic [3:0]        dec0_next;
    logic [3:0]        dec1_next;
    logic              running_reg;
    logic              done_reg;
    logic              tick;
    logic              at_term;

    assign tick = (state_reg == ST_RUN) && (tick_cnt_reg == TICK_LAST);

    // Next BCD value for one step; the terminal case wraps naturally (99->00, 00->99).
    always_comb begin
        dec0_next = dec0_reg;
        dec1_next = dec1_reg;
        at_term   = 1'b0;
        if (up_sync) begin
            at_term = (dec1_reg == 4'd9) && (dec0_reg == 4'd9);
            if (dec0_reg == 4'd9) begin
                dec0_next = 4'd0;
                dec1_next = (dec1_reg == 4'd9) ? 4'd0 : dec1_reg + 4'd1;
            end else begin
                dec0_next = dec0_reg + 4'd1;
            end
        end else begin
            at_term = (dec1_reg == 4'd0) && (dec0_reg == 4'd0);
            if (dec0_reg == 4'd0) begin
                dec0_next = 4'd9;
                dec1_next = (dec1_reg == 4'd0) ? 4'd9 : dec1_reg - 4'd1;
            end else begin
                dec0_next = dec0_reg - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            tick_cnt_reg <= '0;
            dec0_reg     <= 4'd0;
            dec1_reg     <= 4'd0;
            running_reg  <= 1'b0;
            done_reg     <= 1'b0;
        end else if (clr_p) begin
            state_reg    <= ST_IDLE;
            tick_cnt_reg <= '0;
            dec0_reg     <= 4'd0;
            dec1_reg     <= 4'd0;
            running_reg  <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    tick_cnt_reg <= '0;
                    if (run_p) begin
                        state_reg   <= ST_RUN;
                        running_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A stop discards the partial tick period and beats a coincident tick.
                    if (run_p) begin
                        state_reg    <= ST_IDLE;
                        running_reg  <= 1'b0;
                        tick_cnt_reg <= '0;
                    end else if (tick) begin
                        tick_cnt_reg <= '0;
                        if (at_term && !WRAP) begin
                            state_reg   <= ST_DONE;
                            running_reg <= 1'b0;
                            done_reg    <= 1'b1;
                        end else begin
                            dec0_reg <= dec0_next;
                            dec1_reg <= dec1_next;
                        end
                    end else begin
                        tick_cnt_reg <= tick_cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    tick_cnt_reg <= '0;
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    tick_cnt_reg <= '0;
                    running_reg  <= 1'b0;
                    done_reg     <= 1'b0;
                end
            endcase
        end
    end

    // Scan clock divider runs independently of the counter state and of clear.
    logic [DISP_W-1:0] disp_cnt_reg;
    logic              clk_500_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_cnt_reg <= '0;
            clk_500_reg  <= 1'b0;
        end else if (disp_cnt_reg == DISP_LAST) begin
            disp_cnt_reg <= '0;
            clk_500_reg  <= ~clk_500_reg;
        end else begin
            disp_cnt_reg <= disp_cnt_reg + 1'b1;
        end
    end

    assign dec0      = dec0_reg;
    assign dec1      = dec1_reg;
    assign clk_500Hz = clk_500_reg;
    assign running   = running_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Scoreboard bench: a wrapping and a stopping counter share one stimulus stream;
// expectations are queued with the clock edge they are due on and compared there.
module tb_bcd_digit_counter;

    logic       clk;
    logic       rst_n;
    logic       btn_run;
    logic       btn_clear;
    logic       up_dn;

    logic [3:0] w_dec0, w_dec1, s_dec0, s_dec1;
    logic       w_clk, w_running, w_done;
    logic       s_clk, s_running, s_done;

    bcd_digit_counter #(
        .CLK_HZ (1000),
        .TICK_HZ(100),
        .DISP_HZ(100),
        .WRAP   (1'b1)
    ) u_dut_wrap (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_run  (btn_run),
        .btn_clear(btn_clear),
        .up_dn    (up_dn),
        .dec0     (w_dec0),
        .dec1     (w_dec1),
        .clk_500Hz(w_clk),
        .running  (w_running),
        .done     (w_done)
    );

    bcd_digit_counter #(
        .CLK_HZ (1000),
        .TICK_HZ(100),
        .DISP_HZ(100),
        .WRAP   (1'b0)
    ) u_dut_stop (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_run  (btn_run),
        .btn_clear(btn_clear),
        .up_dn    (up_dn),
        .dec0     (s_dec0),
        .dec1     (s_dec1),
        .clk_500Hz(s_clk),
        .running  (s_running),
        .done     (s_done)
    );

    localparam int SEL_W_VAL = 0, SEL_W_RUN = 1, SEL_W_DONE = 2, SEL_W_CLK = 3;
    localparam int SEL_S_VAL = 4, SEL_S_RUN = 5, SEL_S_DONE = 6, SEL_S_CLK = 7;

    typedef struct {
        string tag;
        int    sel;
        int    due;
        int    exp;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end else begin
            $display("ok   %s @edge %0d: 0x%0h", tag, cyc, obs);
        end
    endtask

    function automatic int bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    function automatic int obs_of(input int sel);
        case (sel)
            SEL_W_VAL:  return int'({w_dec1, w_dec0});
            SEL_W_RUN:  return int'(w_running);
            SEL_W_DONE: return int'(w_done);
            SEL_W_CLK:  return int'(w_clk);
            SEL_S_VAL:  return int'({s_dec1, s_dec0});
            SEL_S_RUN:  return int'(s_running);
            SEL_S_DONE: return int'(s_done);
            default:    return int'(s_clk);
        endcase
    endfunction

    task automatic expect_at(input string tag, input int sel, input int due, input int exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.due = due;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Compare every queued expectation that falls due on the edge just taken.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due <= cyc) begin
                check_val(sb_q[i].tag, obs_of(sb_q[i].sel), sb_q[i].exp);
                sb_q.delete(i);
            end
        end
    end

    // Returns just after the falling edge that follows clock edge t.
    task automatic wait_until(input int t);
        do @(negedge clk); while (cyc < t);
        #1;
    endtask

    task automatic push_scan(input int r);
        expect_at("scan_lo_e4",  SEL_W_CLK, r + 4,  0);
        expect_at("scan_hi_e5",  SEL_W_CLK, r + 5,  1);
        expect_at("scan_hi_e9",  SEL_W_CLK, r + 9,  1);
        expect_at("scan_lo_e10", SEL_W_CLK, r + 10, 0);
        expect_at("scan_hi_e15", SEL_W_CLK, r + 15, 1);
        expect_at("scan_s_e15",  SEL_S_CLK, r + 15, 1);
        expect_at("scan_lo_e20", SEL_W_CLK, r + 20, 0);
        expect_at("post_rst_val",  SEL_W_VAL,  r + 1, 0);
        expect_at("post_rst_run",  SEL_W_RUN,  r + 1, 0);
        expect_at("post_rst_done", SEL_S_DONE, r + 1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, r2, c, e, s, e2, e3, e4;
        rst_n     = 1'b0;
        btn_run   = 1'b0;
        btn_clear = 1'b0;
        up_dn     = 1'b1;

        // Reset state, then scan clock phase after release.
        wait_until(3);
        check_val("rst_val_w", int'({w_dec1, w_dec0}), 0);
        check_val("rst_run_w", int'(w_running), 0);
        check_val("rst_clk_w", int'(w_clk), 0);
        check_val("rst_done_s", int'(s_done), 0);
        rst_n = 1'b1;
        r = cyc;
        push_scan(r);

        // Up count from 00, first step TICK_DIV edges after RUN entry.
        c = r + 10;
        wait_until(c);
        btn_run = 1'b1;
        expect_at("run_lat_pre", SEL_W_RUN, c + 2, 0);
        expect_at("run_lat",     SEL_W_RUN, c + 3, 1);
        e = c + 3;
        expect_at("first_pre", SEL_W_VAL, e + 9,  bcd(0));
        expect_at("first_inc", SEL_W_VAL, e + 10, bcd(1));
        expect_at("inc_2",     SEL_W_VAL, e + 20, bcd(2));
        expect_at("inc_6",     SEL_W_VAL, e + 69, bcd(6));
        expect_at("inc_7",     SEL_W_VAL, e + 70, bcd(7));
        wait_until(c + 4);
        btn_run = 1'b0;

        // Pause at 07 mid-period and hold for 50 cycles.
        wait_until(e + 72);
        btn_run = 1'b1;
        s = e + 75;
        expect_at("stop_pre",   SEL_W_RUN, s - 1,  1);
        expect_at("stop_run",   SEL_W_RUN, s,      0);
        expect_at("stop_hold1", SEL_W_VAL, e + 80, bcd(7));
        expect_at("stop_hold2", SEL_W_VAL, s + 50, bcd(7));
        wait_until(e + 76);
        btn_run = 1'b0;

        // Resume: partial period discarded, then carry 09 -> 10.
        wait_until(s + 55);
        btn_run = 1'b1;
        e2 = s + 58;
        expect_at("resume_run",  SEL_W_RUN, e2,      1);
        expect_at("resume_pre",  SEL_W_VAL, e2 + 9,  bcd(7));
        expect_at("resume_inc",  SEL_W_VAL, e2 + 10, bcd(8));
        expect_at("carry_pre",   SEL_W_VAL, e2 + 29, bcd(9));
        expect_at("carry_10",    SEL_W_VAL, e2 + 30, bcd(10));
        wait_until(s + 59);
        btn_run = 1'b0;

        // Run and clear together while running: clear wins.
        c = e2 + 35;
        wait_until(c);
        btn_run   = 1'b1;
        btn_clear = 1'b1;
        expect_at("clr_pre_val", SEL_W_VAL, c + 2,  bcd(10));
        expect_at("clr_pre_run", SEL_W_RUN, c + 2,  1);
        expect_at("clr_val",     SEL_W_VAL, c + 3,  0);
        expect_at("clr_run",     SEL_W_RUN, c + 3,  0);
        expect_at("clr_val_s",   SEL_S_VAL, c + 3,  0);
        expect_at("clr_idle",    SEL_W_VAL, c + 20, 0);
        wait_until(c + 4);
        btn_run   = 1'b0;
        btn_clear = 1'b0;

        // Direction flip at 05, then down through 00.
        c = c + 25;
        wait_until(c);
        btn_run = 1'b1;
        e3 = c + 3;
        expect_at("dir_run",  SEL_W_RUN, e3,      1);
        expect_at("dir_at5",  SEL_W_VAL, e3 + 50, bcd(5));
        wait_until(c + 4);
        btn_run = 1'b0;
        wait_until(e3 + 52);
        up_dn = 1'b0;
        expect_at("dir_hold5",  SEL_W_VAL,  e3 + 59,  bcd(5));
        expect_at("dir_down4",  SEL_W_VAL,  e3 + 60,  bcd(4));
        expect_at("dir_down3",  SEL_W_VAL,  e3 + 70,  bcd(3));
        expect_at("dir_down0",  SEL_W_VAL,  e3 + 100, bcd(0));
        expect_at("dn_pre_run_s",  SEL_S_RUN,  e3 + 109, 1);
        expect_at("dn_pre_done_s", SEL_S_DONE, e3 + 109, 0);
        expect_at("wrap_dn_val",   SEL_W_VAL,  e3 + 110, bcd(99));
        expect_at("wrap_dn_run",   SEL_W_RUN,  e3 + 110, 1);
        expect_at("stop_dn_val",   SEL_S_VAL,  e3 + 110, bcd(0));
        expect_at("stop_dn_done",  SEL_S_DONE, e3 + 110, 1);
        expect_at("stop_dn_run",   SEL_S_RUN,  e3 + 110, 0);

        // Wrapping counter goes back up: 99 -> 00.
        wait_until(e3 + 112);
        up_dn = 1'b1;
        expect_at("wrap_up_pre", SEL_W_VAL, e3 + 119, bcd(99));
        expect_at("wrap_up_val", SEL_W_VAL, e3 + 120, bcd(0));
        expect_at("wrap_up_run", SEL_W_RUN, e3 + 120, 1);

        // Run press: stops the wrapping counter, ignored in DONE.
        c = e3 + 125;
        wait_until(c);
        btn_run = 1'b1;
        expect_at("done_ign_wrun", SEL_W_RUN,  c + 3,  0);
        expect_at("done_ign_run",  SEL_S_RUN,  c + 3,  0);
        expect_at("done_ign_done", SEL_S_DONE, c + 3,  1);
        expect_at("done_ign_hold", SEL_S_DONE, c + 10, 1);
        expect_at("done_ign_val",  SEL_S_VAL,  c + 10, bcd(0));
        expect_at("wstop_hold",    SEL_W_VAL,  c + 20, bcd(0));
        wait_until(c + 4);
        btn_run = 1'b0;

        // Clear leaves DONE.
        c = c + 25;
        wait_until(c);
        btn_clear = 1'b1;
        expect_at("done_clr_pre", SEL_S_DONE, c + 2, 1);
        expect_at("done_clr",     SEL_S_DONE, c + 3, 0);
        expect_at("done_clr_run", SEL_S_RUN,  c + 3, 0);
        wait_until(c + 4);
        btn_clear = 1'b0;

        // Count both up to 99; stopping counter holds 99, wrapping one rolls over.
        c = c + 10;
        wait_until(c);
        btn_run = 1'b1;
        e4 = c + 3;
        for (int k = 1; k <= 99; k++) begin
            expect_at("up_seq", SEL_S_VAL, e4 + 10 * k, bcd(k));
        end
        expect_at("term_pre_run",  SEL_S_RUN,  e4 + 999,  1);
        expect_at("term_pre_done", SEL_S_DONE, e4 + 999,  0);
        expect_at("term_val_s",    SEL_S_VAL,  e4 + 1000, bcd(99));
        expect_at("term_done_s",   SEL_S_DONE, e4 + 1000, 1);
        expect_at("term_run_s",    SEL_S_RUN,  e4 + 1000, 0);
        expect_at("term_val_w",    SEL_W_VAL,  e4 + 1000, bcd(0));
        expect_at("term_run_w",    SEL_W_RUN,  e4 + 1000, 1);
        expect_at("term_next_w",   SEL_W_VAL,  e4 + 1010, bcd(1));
        expect_at("term_hold_s",   SEL_S_VAL,  e4 + 1010, bcd(99));
        wait_until(c + 4);
        btn_run = 1'b0;

        // Asynchronous reset mid-run while the scan clock is high.
        wait_until(e4 + 1015);
        while (((cyc - r) % 10) != 6) wait_until(cyc + 1);
        check_val("pre_rst_clk",  int'(w_clk), 1);
        check_val("pre_rst_run",  int'(w_running), 1);
        check_val("pre_rst_done", int'(s_done), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("async_val_w",  int'({w_dec1, w_dec0}), 0);
        check_val("async_run_w",  int'(w_running), 0);
        check_val("async_clk_w",  int'(w_clk), 0);
        check_val("async_val_s",  int'({s_dec1, s_dec0}), 0);
        check_val("async_done_s", int'(s_done), 0);
        wait_until(cyc + 2);
        rst_n = 1'b1;
        r2 = cyc;
        push_scan(r2);

        wait_until(r2 + 25);
        check_val("sb_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
